// File: rtl/sensor_feature_extractor_if.sv
// Sample stream and feature-record handshake bundle for sensor_feature_extractor.
// slave = extractor side, master = sample source / register-slave side.
interface sensor_feature_extractor_if #(
    parameter int DATA_WIDTH = 16,
    parameter int WIN_LOG2   = 3
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  feat_valid;
    logic                  feat_ready;
    logic [DATA_WIDTH-1:0] feat_mean;
    logic [DATA_WIDTH-1:0] feat_max;
    logic [DATA_WIDTH-1:0] feat_min;
    logic [WIN_LOG2:0]     feat_over_cnt;

    modport slave (
        input  s_valid, s_data, feat_ready,
        output s_ready, feat_valid, feat_mean, feat_max, feat_min, feat_over_cnt
    );

    modport master (
        output s_valid, s_data, feat_ready,
        input  s_ready, feat_valid, feat_mean, feat_max, feat_min, feat_over_cnt
    );
endinterface

// File: rtl/sensor_feature_extractor.sv
// Windowed mean/max/min/over-threshold feature extractor with a held output record.
// Optional sticky alarm is built only when FEAT_ALARM_EN is defined.
module sensor_feature_extractor #(
    parameter int DATA_WIDTH = 16,
    parameter int WIN_LOG2   = 3
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cfg_enable,
    input  logic [DATA_WIDTH-1:0] cfg_threshold,
    input  logic [WIN_LOG2:0]     cfg_alarm_level,
    input  logic                  alarm_clr,
    sensor_feature_extractor_if.slave bus,
    output logic                  alarm
);
    localparam int SUM_W = DATA_WIDTH + WIN_LOG2;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [WIN_LOG2-1:0] LAST_IDX = {WIN_LOG2{1'b1}};
    localparam logic [WIN_LOG2-1:0] ZERO_IDX = {WIN_LOG2{1'b0}};

    logic [1:0]            state_r;
    logic [1:0]            next_state_s;
    logic                  s_ready_r;
    logic                  feat_valid_r;
    logic [SUM_W-1:0]      sum_r;
    logic [DATA_WIDTH-1:0] max_r;
    logic [DATA_WIDTH-1:0] min_r;
    logic [WIN_LOG2:0]     over_r;
    logic [WIN_LOG2-1:0]   idx_r;
    logic [DATA_WIDTH-1:0] mean_out_r;
    logic [DATA_WIDTH-1:0] max_out_r;
    logic [DATA_WIDTH-1:0] min_out_r;
    logic [WIN_LOG2:0]     over_out_r;

    logic                  accept_s;
    logic                  first_s;
    logic                  win_done_s;
    logic                  keep_accum_s;
    logic [SUM_W-1:0]      sum_nxt_s;
    logic [DATA_WIDTH-1:0] max_nxt_s;
    logic [DATA_WIDTH-1:0] min_nxt_s;
    logic [WIN_LOG2:0]     over_nxt_s;

    assign accept_s     = bus.s_valid && s_ready_r;
    assign first_s      = (idx_r == ZERO_IDX);
    assign sum_nxt_s    = sum_r + SUM_W'(bus.s_data);
    assign max_nxt_s    = (first_s || (bus.s_data > max_r)) ? bus.s_data : max_r;
    assign min_nxt_s    = (first_s || (bus.s_data < min_r)) ? bus.s_data : min_r;
    assign over_nxt_s   = over_r + {{WIN_LOG2{1'b0}}, (bus.s_data >= cfg_threshold)};
    assign win_done_s   = (state_r == ACCUM) && (next_state_s == HOLD);
    assign keep_accum_s = (state_r == ACCUM) && (next_state_s == ACCUM);

    // Window control; a disable in ACCUM wins over a completing sample so the partial window is dropped.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cfg_enable) next_state_s = ACCUM;
                else            next_state_s = IDLE;
            end
            ACCUM: begin
                if (!cfg_enable)                          next_state_s = IDLE;
                else if (accept_s && (idx_r == LAST_IDX)) next_state_s = HOLD;
                else                                      next_state_s = ACCUM;
            end
            HOLD: begin
                if (bus.feat_ready) next_state_s = cfg_enable ? ACCUM : IDLE;
                else                next_state_s = HOLD;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State plus handshake flags registered from the next state so they track it exactly.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r      <= IDLE;
            s_ready_r    <= 1'b0;
            feat_valid_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            s_ready_r    <= (next_state_s == ACCUM);
            feat_valid_r <= (next_state_s == HOLD);
        end
    end

    // Accumulators only live while staying in ACCUM; every other cycle leaves them clean for the next window.
    always_ff @(posedge ACLK) begin
        if (ARESET || !keep_accum_s) begin
            sum_r  <= {SUM_W{1'b0}};
            max_r  <= {DATA_WIDTH{1'b0}};
            min_r  <= {DATA_WIDTH{1'b0}};
            over_r <= {(WIN_LOG2+1){1'b0}};
            idx_r  <= ZERO_IDX;
        end else if (accept_s) begin
            sum_r  <= sum_nxt_s;
            max_r  <= max_nxt_s;
            min_r  <= min_nxt_s;
            over_r <= over_nxt_s;
            idx_r  <= idx_r + {{(WIN_LOG2-1){1'b0}}, 1'b1};
        end
    end

    // Feature record captured from the final sample's updated statistics and held through HOLD.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            mean_out_r <= {DATA_WIDTH{1'b0}};
            max_out_r  <= {DATA_WIDTH{1'b0}};
            min_out_r  <= {DATA_WIDTH{1'b0}};
            over_out_r <= {(WIN_LOG2+1){1'b0}};
        end else if (win_done_s) begin
            mean_out_r <= sum_nxt_s[SUM_W-1:WIN_LOG2];
            max_out_r  <= max_nxt_s;
            min_out_r  <= min_nxt_s;
            over_out_r <= over_nxt_s;
        end
    end

    assign bus.s_ready       = s_ready_r;
    assign bus.feat_valid    = feat_valid_r;
    assign bus.feat_mean     = mean_out_r;
    assign bus.feat_max      = max_out_r;
    assign bus.feat_min      = min_out_r;
    assign bus.feat_over_cnt = over_out_r;

`ifdef FEAT_ALARM_EN
    logic alarm_r;
    logic alarm_set_s;

    assign alarm_set_s = win_done_s && (cfg_alarm_level != {(WIN_LOG2+1){1'b0}})
                         && (over_nxt_s >= cfg_alarm_level);

    // Sticky alarm raised together with the record it describes; a set beats a same-cycle clear.
    always_ff @(posedge ACLK) begin
        if (ARESET)           alarm_r <= 1'b0;
        else if (alarm_set_s) alarm_r <= 1'b1;
        else if (alarm_clr)   alarm_r <= 1'b0;
    end

    assign alarm = alarm_r;
`else
    logic unused_alarm_s;
    assign unused_alarm_s = ^{alarm_clr, cfg_alarm_level};
    assign alarm = 1'b0;
`endif
endmodule

// File: doc/sensor_feature_extractor.md
SENSOR_FEATURE_EXTRACTOR -- requirements
Module: sensor_feature_extractor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, unsigned sample width.
REQ-002 SHALL have parameter WIN_LOG2, default 3, window length N = 2^WIN_LOG2 samples; legal range 1..8.
REQ-003 SHALL have port ACLK  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port ARESET  in  1  synchronous, active-high reset.
REQ-005 SHALL have port cfg_enable  in  1  extractor enable, driven from the PredictiveAnalysis_IP control register.
REQ-006 SHALL have port cfg_threshold  in  DATA_WIDTH  over-threshold compare level.
REQ-007 SHALL have port cfg_alarm_level  in  WIN_LOG2+1  alarm trigger count.
REQ-008 SHALL have port alarm_clr  in  1  single-cycle alarm clear pulse.
REQ-009 SHALL have port s_valid / s_ready / s_data  in / out / in  1 / 1 / DATA_WIDTH  sensor sample stream.
REQ-010 SHALL have port feat_valid / feat_ready  out / in  1 / 1  feature record handshake toward the register slave.
REQ-011 SHALL have port feat_mean, feat_max, feat_min  out  DATA_WIDTH each  window statistics.
REQ-012 SHALL have port feat_over_cnt  out  WIN_LOG2+1  samples >= cfg_threshold in window.
REQ-013 SHALL have port alarm  out  1  sticky predictive-maintenance alarm.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-015 IDLE -> ACCUM on cfg_enable=1; accumulators (sum, max, min, over count, sample index) cleared on entry.
REQ-016 s_ready SHALL be 1 only in ACCUM; a sample is accepted when s_valid && s_ready.
REQ-017 Per accepted sample: sum += s_data (width DATA_WIDTH+WIN_LOG2, never overflows); max/min updated; over count += 1 when s_data >= cfg_threshold (equality counts).
REQ-018 First sample of a window SHALL initialise max and min to that sample.
REQ-019 On acceptance of sample N, next state HOLD; feat_valid SHALL assert the cycle after that handshake (latency 1) with the final window statistics registered.
REQ-020 feat_mean SHALL equal sum >> WIN_LOG2 (truncation, no rounding).
REQ-021 In HOLD, feat_valid=1 and all feat_* outputs SHALL stay stable until feat_ready=1.
REQ-022 On feat_valid && feat_ready: next state ACCUM with cleared accumulators if cfg_enable=1, else IDLE; feat_valid deasserts the following cycle.
REQ-023 cfg_enable=0 in ACCUM SHALL discard the partial window and enter IDLE next cycle; no feat_valid produced.
REQ-024 cfg_enable=0 in HOLD SHALL NOT drop the pending record; exit per REQ-022.
REQ-025 cfg_threshold and cfg_alarm_level SHALL be sampled live each cycle; changes mid-window affect only subsequent samples.

Reset
REQ-026 ARESET=1 SHALL force IDLE and clear all accumulators regardless of state, including mid-window or in HOLD.
REQ-027 Reset values: s_ready=0, feat_valid=0, feat_mean=0, feat_max=0, feat_min=0, feat_over_cnt=0, alarm=0.

Configuration
REQ-028 Macro FEAT_ALARM_EN SHALL gate the alarm logic.
REQ-029 With FEAT_ALARM_EN defined: alarm sets on the cycle feat_valid first asserts with feat_over_cnt >= cfg_alarm_level (cfg_alarm_level=0 never sets), stays set until alarm_clr=1; simultaneous set and clear SHALL resolve to set.
REQ-030 Without FEAT_ALARM_EN: alarm tied to 0, alarm_clr and cfg_alarm_level ignored, no alarm registers synthesised.

Verification (WIN_LOG2=3, DATA_WIDTH=16)
REQ-031 Samples 1..8 back-to-back, threshold 5 -> feat_mean=4, max=8, min=1, over_cnt=4, feat_valid one cycle after 8th handshake.
REQ-032 Eight samples 0xFFFF, threshold 0xFFFF -> feat_mean=0xFFFF, max=min=0xFFFF, over_cnt=8 (no sum overflow, equality counted).
REQ-033 feat_ready held 0 for 10 cycles after feat_valid -> s_ready=0 throughout, feat_* unchanged; after handshake next window accepted normally.
REQ-034 cfg_enable dropped after 3 samples -> no feat_valid; re-enable, samples 10x8 -> feat_mean=10, min=10 (no stale data).
REQ-035 FEAT_ALARM_EN defined, level 4, window with 5 over-threshold samples -> alarm=1, persists across next clean window, clears on alarm_clr pulse.
REQ-036 ARESET pulsed after 5 samples and again while in HOLD -> all outputs return to reset values next cycle; subsequent window produces correct statistics.
